// File: rtl/pll_digital_pfd.sv
// pll_digital_pfd
//   Clocked time-to-digital phase/frequency detector for the AMS PLL.
//   The reference clock and the divided feedback clock are both oversampled
//   by clk. Rising edges open and close a measurement. Each closed
//   measurement reports a signed phase error in clk cycles, with positive
//   meaning the reference leads. The block also drives UP/DN pulses for the
//   charge pump, a cycle-slip strobe and a lock indicator.
//
// Ports
//   clk       in   sampling clock, rising edge
//   rst       in   synchronous reset, active-high
//   ref_in    in   reference clock, asynchronous to clk
//   fb_in     in   divided feedback clock, asynchronous to clk
//   up        out  high while a reference-leading measurement is open
//   dn        out  high while a feedback-leading measurement is open
//   err       out  signed CNT_W+1 phase error, held between strobes
//   err_valid out  one-cycle strobe, err updated in the same cycle
//   slip      out  one-cycle cycle-slip strobe, only with err_valid
//   locked    out  lock indicator, lags err_valid by one cycle
module pll_digital_pfd #(
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_TOL    = 2,
   parameter int LOCK_CNT    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ref_in,
   input  logic                    fb_in,
   output logic                    up,
   output logic                    dn,
   output logic signed [CNT_W:0]   err,
   output logic                    err_valid,
   output logic                    slip,
   output logic                    locked
);

   localparam logic [CNT_W-1:0]     MAX    = '1;
   localparam int                   MSK_N  = SYNC_STAGES + 1;
   localparam int                   MSK_W  = $clog2(MSK_N + 1);
   localparam int                   GOOD_W = $clog2(LOCK_CNT + 1);
   localparam logic signed [CNT_W:0] TOL   = (CNT_W+1)'(LOCK_TOL);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REF_LEAD = 2'd1,
      FB_LEAD  = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == MAX) ? MAX : v + 1'b1;
   endfunction

   function automatic logic signed [CNT_W:0] to_err(input logic [CNT_W-1:0] v,
                                                     input logic neg);
      logic signed [CNT_W:0] m;
      m = $signed({1'b0, v});
      return neg ? -m : m;
   endfunction

   function automatic logic is_good(input logic signed [CNT_W:0] e,
                                    input logic s);
      return (e <= TOL) && (e >= -TOL) && !s;
   endfunction

   // ---- stage p0/p1: synchronizers, previous-value registers, arming ----
   logic [SYNC_STAGES-1:0] ref_sync_p0, fb_sync_p0;
   logic                   ref_prev_p1, fb_prev_p1;
   logic [MSK_W-1:0]       msk_cnt;
   logic                   armed;
   logic                   ref_edge, fb_edge;

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_sync_p0 <= '0;
         fb_sync_p0  <= '0;
         ref_prev_p1 <= 1'b0;
         fb_prev_p1  <= 1'b0;
         msk_cnt     <= '0;
      end else begin
         ref_sync_p0 <= {ref_sync_p0[SYNC_STAGES-2:0], ref_in};
         fb_sync_p0  <= {fb_sync_p0[SYNC_STAGES-2:0], fb_in};
         ref_prev_p1 <= ref_sync_p0[SYNC_STAGES-1];
         fb_prev_p1  <= fb_sync_p0[SYNC_STAGES-1];
         if (!armed)
            msk_cnt <= msk_cnt + 1'b1;
      end
   end

   // Edges stay masked until the previous-value registers have caught up
   // with the synchronizers. An input that is already high at reset release
   // then never shows up as an edge.
   assign armed    = (msk_cnt == MSK_W'(MSK_N));
   assign ref_edge = armed & ref_sync_p0[SYNC_STAGES-1] & ~ref_prev_p1;
   assign fb_edge  = armed & fb_sync_p0[SYNC_STAGES-1]  & ~fb_prev_p1;

   // ---- stage p2: measurement FSM and phase-error outputs ----
   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic signed [CNT_W:0] err_p2, err_nxt;
   logic                  vld_p2, vld_nxt;
   logic                  slip_p2, slip_nxt;
   logic                  up_p2, dn_p2;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = err_p2;
      vld_nxt   = 1'b0;
      slip_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (ref_edge && fb_edge) begin
               err_nxt = '0;
               vld_nxt = 1'b1;
            end else if (ref_edge) begin
               state_nxt = REF_LEAD;
               cnt_nxt   = CNT_W'(1);
            end else if (fb_edge) begin
               state_nxt = FB_LEAD;
               cnt_nxt   = CNT_W'(1);
            end
         end
         REF_LEAD: begin
            case ({ref_edge, fb_edge})
               2'b00: cnt_nxt = sat_inc(cnt);
               2'b01: begin
                  err_nxt   = to_err(cnt, 1'b0);
                  vld_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
               2'b10: begin
                  // Second reference edge with no feedback edge: a slip.
                  err_nxt  = to_err(MAX, 1'b0);
                  vld_nxt  = 1'b1;
                  slip_nxt = 1'b1;
                  cnt_nxt  = CNT_W'(1);
               end
               default: begin
                  // The fb edge closes this measurement and the ref edge
                  // opens the next one.
                  err_nxt = to_err(cnt, 1'b0);
                  vld_nxt = 1'b1;
                  cnt_nxt = CNT_W'(1);
               end
            endcase
         end
         FB_LEAD: begin
            case ({ref_edge, fb_edge})
               2'b00: cnt_nxt = sat_inc(cnt);
               2'b10: begin
                  err_nxt   = to_err(cnt, 1'b1);
                  vld_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
               2'b01: begin
                  err_nxt  = to_err(MAX, 1'b1);
                  vld_nxt  = 1'b1;
                  slip_nxt = 1'b1;
                  cnt_nxt  = CNT_W'(1);
               end
               default: begin
                  err_nxt = to_err(cnt, 1'b1);
                  vld_nxt = 1'b1;
                  cnt_nxt = CNT_W'(1);
               end
            endcase
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         err_p2  <= '0;
         vld_p2  <= 1'b0;
         slip_p2 <= 1'b0;
         up_p2   <= 1'b0;
         dn_p2   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         err_p2  <= err_nxt;
         vld_p2  <= vld_nxt;
         slip_p2 <= slip_nxt;
         up_p2   <= (state_nxt == REF_LEAD);
         dn_p2   <= (state_nxt == FB_LEAD);
      end
   end

   // ---- stage p3: lock qualification of each reported measurement ----
   logic [GOOD_W-1:0] good_cnt, good_nxt;
   logic              locked_p3;

   assign good_nxt = (good_cnt == GOOD_W'(LOCK_CNT)) ? good_cnt : good_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         good_cnt  <= '0;
         locked_p3 <= 1'b0;
      end else if (vld_p2) begin
         if (is_good(err_p2, slip_p2)) begin
            good_cnt  <= good_nxt;
            locked_p3 <= (good_nxt == GOOD_W'(LOCK_CNT));
         end else begin
            good_cnt  <= '0;
            locked_p3 <= 1'b0;
         end
      end
   end

   assign up        = up_p2;
   assign dn        = dn_p2;
   assign err       = err_p2;
   assign err_valid = vld_p2;
   assign slip      = slip_p2;
   assign locked    = locked_p3;

endmodule

// File: tb/tb_pll_digital_pfd.sv
module tb_pll_digital_pfd;

   logic              clk = 1'b0;
   logic              rst;
   logic              ref_in, fb_in;
   logic              up, dn, err_valid, slip, locked;
   logic signed [8:0] err;

   pll_digital_pfd #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_TOL(2), .LOCK_CNT(16)) dut (
      .clk(clk), .rst(rst), .ref_in(ref_in), .fb_in(fb_in),
      .up(up), .dn(dn), .err(err), .err_valid(err_valid),
      .slip(slip), .locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [8:0] err;
      logic              slip;
   } exp_t;

   typedef struct {
      int gap;   // >0: ref leads by gap cycles, <0: fb leads
      int err;
   } vec_t;

   exp_t q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   up_cyc = 0, dn_cyc = 0, overlap = 0;
   int   tb_good = 0;
   bit   tb_lock = 1'b0;
   bit   lock_pend = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input int v, input bit s);
      exp_t x;
      x.err  = v[8:0];
      x.slip = s;
      q.push_back(x);
   endtask

   // Scoreboard: strobes are popped and checked here; the lock model is
   // driven only by the expected values, never by the DUT outputs.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         tb_good   = 0;
         tb_lock   = 1'b0;
         lock_pend = 1'b0;
      end else begin
         if (lock_pend) begin
            chk("locked_update", int'(locked), int'(tb_lock));
            lock_pend = 1'b0;
         end
         if (up) up_cyc++;
         if (dn) dn_cyc++;
         if (up && dn) overlap++;
         if (slip && !err_valid) begin
            n_vec++; n_err++;
            $display("FAIL slip_without_strobe: got slip=1, required slip=0");
         end
         if (err_valid) begin
            chk("locked_lag", int'(locked), int'(tb_lock));
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_strobe: got err=%0d slip=%0b, required no strobe", err, slip);
            end else begin
               e = q.pop_front();
               chk("err", int'(err), int'(e.err));
               chk("slip", int'(slip), int'(e.slip));
               if (!e.slip && e.err <= 2 && e.err >= -2) begin
                  if (tb_good < 16) tb_good++;
               end else begin
                  tb_good = 0;
               end
               tb_lock   = (tb_good == 16);
               lock_pend = 1'b1;
            end
         end
      end
   end

   function automatic bit in_p(input int c, input int s);
      return (s >= 0) && (c >= s) && (c < s + 2);
   endfunction

   // Two-cycle pulses starting at the given cycle offsets; -1 means unused.
   task automatic run_pulses(input int len, input int r0, input int r1,
                             input int f0, input int f1);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         ref_in = in_p(c, r0) || in_p(c, r1);
         fb_in  = in_p(c, f0) || in_p(c, f1);
      end
      @(negedge clk);
      ref_in = 1'b0;
      fb_in  = 1'b0;
   endtask

   task automatic run_vec(input int g);
      if (g >= 0) run_pulses(g + 4, 0, -1, g, -1);
      else        run_pulses(-g + 4, -g, -1, 0, -1);
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (q.size() != 0 && i < 40) begin
         @(negedge clk);
         i++;
      end
      chk("drain_queue", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_up"}, int'(up), 0);
      chk({tag, "_dn"}, int'(dn), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_err_valid"}, int'(err_valid), 0);
      chk({tag, "_slip"}, int'(slip), 0);
      chk({tag, "_locked"}, int'(locked), 0);
   endtask

   vec_t vt[12];
   int   u0, d0, g;

   initial begin
      vt[0]  = '{5, 5};      vt[1]  = '{-7, -7};
      vt[2]  = '{1, 1};      vt[3]  = '{-1, -1};
      vt[4]  = '{12, 12};    vt[5]  = '{-3, -3};
      vt[6]  = '{64, 64};    vt[7]  = '{-100, -100};
      vt[8]  = '{255, 255};  vt[9]  = '{256, 255};
      vt[10] = '{300, 255};  vt[11] = '{-300, -255};

      // Reset with ref already high: no spurious edge after release.
      rst = 1'b1; ref_in = 1'b1; fb_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      u0 = up_cyc;
      repeat (12) @(negedge clk);
      chk("no_spurious_up", up_cyc - u0, 0);
      ref_in = 1'b0;
      repeat (4) @(negedge clk);

      // Table of single measurements, including counter saturation.
      for (int i = 0; i < 12; i++) begin
         u0 = up_cyc; d0 = dn_cyc;
         push_exp(vt[i].err, 1'b0);
         run_vec(vt[i].gap);
         drain();
         chk("up_cycles", up_cyc - u0, (vt[i].gap > 0) ? vt[i].gap : 0);
         chk("dn_cycles", dn_cyc - d0, (vt[i].gap < 0) ? -vt[i].gap : 0);
      end

      // Simultaneous edges, ten times.
      u0 = up_cyc; d0 = dn_cyc;
      for (int i = 0; i < 10; i++) begin
         push_exp(0, 1'b0);
         run_vec(0);
      end
      drain();
      chk("same_edge_up", up_cyc - u0, 0);
      chk("same_edge_dn", dn_cyc - d0, 0);

      // Raw encoding of -7.
      push_exp(-7, 1'b0);
      run_vec(-7);
      drain();
      chk("err_raw_neg7", int'($unsigned(err)), 'h1F9);

      // Reference slip, then fb 3 cycles after the second ref.
      u0 = up_cyc;
      push_exp(255, 1'b1); push_exp(3, 1'b0);
      run_pulses(48, 0, 40, 43, -1);
      drain();
      chk("ref_slip_up_cycles", up_cyc - u0, 43);

      // Feedback slip, then ref 5 cycles after the second fb.
      d0 = dn_cyc;
      push_exp(-255, 1'b1); push_exp(-5, 1'b0);
      run_pulses(40, 35, -1, 0, 30);
      drain();
      chk("fb_slip_dn_cycles", dn_cyc - d0, 35);

      // Both edges while REF_LEAD: close at +10 and reopen.
      u0 = up_cyc;
      push_exp(10, 1'b0); push_exp(4, 1'b0);
      run_pulses(20, 0, 10, 10, 14);
      drain();
      chk("ref_both_up_cycles", up_cyc - u0, 14);

      // Both edges while FB_LEAD.
      d0 = dn_cyc;
      push_exp(-6, 1'b0); push_exp(-3, 1'b0);
      run_pulses(15, 6, 9, 0, 6);
      drain();
      chk("fb_both_dn_cycles", dn_cyc - d0, 9);

      // Lock sequence from a clean reset.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         g = (i % 5) - 2;
         push_exp(g, 1'b0);
         run_vec(g);
         drain();
      end
      chk("locked_after_16", int'(locked), 1);
      push_exp(3, 1'b0);
      run_vec(3);
      drain();
      chk("unlocked_after_bad", int'(locked), 0);

      // Reset in the middle of a reference-leading measurement.
      run_pulses(4, 0, -1, -1, -1);
      repeat (3) @(negedge clk);
      chk("mid_meas_up", int'(up), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("up_after_release", int'(up), 0);

      chk("up_dn_overlap", overlap, 0);
      chk("final_queue", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pll_digital_pfd.md
Name: pll_digital_pfd

Overview:
- Clocked, time-to-digital phase/frequency detector for the AMS PLL.
- Sits directly downstream of the frequency divider and compares the divided feedback clock against the reference clock.
- Produces UP/DN pulses for the charge-pump model, plus a signed phase-error count, a cycle-slip flag and a lock indicator.
- Both inputs are sampled by a fast oversampling clock that is unrelated to either of them.

Parameters:
- CNT_W, 8: phase-error counter width; err is CNT_W+1 bits, signed.
- SYNC_STAGES, 2: synchronizer depth on ref_in and fb_in (minimum 2).
- LOCK_TOL, 2: largest |err| that counts as an in-lock measurement.
- LOCK_CNT, 16: number of consecutive in-lock measurements required to assert locked.

Ports:
- clk, input, 1: sampling clock. One clock; all state is updated on the rising edge of clk.
- rst, input, 1: reset, synchronous, active-high.
- ref_in, input, 1: reference clock, asynchronous to clk.
- fb_in, input, 1: divided feedback clock from the divider output, asynchronous to clk.
- up, output, 1: high while a reference-leading measurement is open.
- dn, output, 1: high while a feedback-leading measurement is open.
- err, output, CNT_W+1 (signed): last measured phase error in clk cycles; positive means the reference leads.
- err_valid, output, 1: one-cycle strobe; err is updated in the same cycle.
- slip, output, 1: one-cycle strobe marking a cycle slip (qualified by err_valid).
- locked, output, 1: lock indicator.

Behaviour:
- Reset values: all outputs 0; err = 0; state IDLE; counters 0; synchronizer and edge registers 0.
- Reset asserted mid-measurement abandons the measurement. No err_valid is produced.
- Each input passes through SYNC_STAGES flops, then a previous-value register.
- A rising edge is defined as synced & ~prev. Detect latency is SYNC_STAGES+1 cycles, identical for both inputs, so it cancels in the measurement.
- Edge detection is masked for SYNC_STAGES+1 cycles after reset release. No spurious edge is produced when an input is already high at release.
- MAX = 2^CNT_W - 1. cnt saturates at MAX and never wraps.
- State IDLE:
  - ref and fb edges in the same cycle: err=0, err_valid=1, stay in IDLE.
  - ref edge only: go to REF_LEAD, cnt=1.
  - fb edge only: go to FB_LEAD, cnt=1.
- State REF_LEAD:
  - No edge: cnt++ (saturating).
  - fb edge only: err=+cnt, err_valid=1, go to IDLE.
  - ref edge only (second ref before any fb): slip=1, err=+MAX, err_valid=1, cnt=1, stay in REF_LEAD.
  - Both edges: err=+cnt, err_valid=1, cnt=1, stay in REF_LEAD. The fb edge closes the old measurement and the ref edge opens a new one.
- State FB_LEAD: mirror of REF_LEAD with signs negated.
  - fb edge only: slip=1, err=-MAX.
  - Both edges: err=-cnt, cnt=1, stay in FB_LEAD.
- up and dn are registered decodes of the state: up=1 exactly in REF_LEAD, dn=1 exactly in FB_LEAD. They are never high together.
- err holds its value between strobes. slip is 0 whenever err_valid is 0.
- Lock logic, evaluated only on err_valid:
  - A measurement is good when |err| <= LOCK_TOL and slip=0.
  - On good: increment the good counter (saturating at LOCK_CNT).
  - On bad: clear the good counter.
  - locked rises the cycle after the good counter reaches LOCK_CNT.
  - locked falls the cycle after any bad measurement.
- Ordering: err_valid and err update in the same cycle; locked lags err_valid by exactly 1 cycle.

Test Plan:
- ref edge, then fb edge 5 clk later: up high for 5 cycles, dn=0 throughout; err=+5 with a single err_valid pulse; state returns to IDLE.
- fb edge, then ref edge 7 clk later: dn high for 7 cycles; err=-7 (9-bit value 0x1F9); slip=0.
- ref and fb edges in the same cycle, repeated 10 times: up=dn=0 throughout; 10 strobes with err=0.
- Two ref edges 40 cycles apart with no fb edge: strobe with slip=1 and err=+255; up stays high; a fb edge 3 cycles later gives err=+3.
- fb edge 300 cycles after ref: cnt saturates; err=+255, slip=0.
- Lock sequence:
  - Apply 16 measurements with err in {-2..+2}: locked=1 one cycle after the 16th strobe.
  - Next measurement err=+3: locked=0 the following cycle.
  - Assert rst mid-REF_LEAD: no strobe; all outputs 0 next cycle.
